render_stream_scheduler: RTL and testbench
==========================================

// Module: render_stream_scheduler
// PURPOSE
//  Head of the render pipeline. Buffers host register writes for the shape stages
//  (ellipse and others), then sequences each frame on the shared program/x/y/data bus.
//  Each frame has two phases: first a burst of queued program words, then a raster scan
//  of background pixels that the downstream shape stages paint over.
//  Config writes arriving mid-scan are deferred to the next frame, so frames never tear.
// PARAMETERS
//  H_ACTIVE   640     pixels per line; x_out runs 0..H_ACTIVE-1
//  V_ACTIVE   480     lines per frame; y_out runs 0..V_ACTIVE-1
//  BG_COLOR   12'h000 data_out value for every scan pixel
//  FIFO_DEPTH 8       config words buffered; power of two, >=2
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  cfg_valid    in   1   host offers a config word
//  cfg_ready    out  1   scheduler accepts; transfer happens when valid&&ready
//  cfg_target   in   12  destination stage index, 0 = first stage; 0..4094 legal
//  cfg_reg_id   in   3   register ID in the stage (0 x,1 y,2 width,3 height,4 colour)
//  cfg_data     in   12  register value
//  frame_go     in   1   start-of-frame request, sampled only in IDLE
//  busy         out  1   high in PROGRAM or SCAN
//  frame_done   out  1   one-cycle pulse coincident with the last scan pixel
//  program_out  out  1   bus: 1 = program word, 0 = pixel
//  x_out        out  12  bus: target index (program word) or pixel x
//  y_out        out  12  bus: register ID (program word) or pixel y
//  data_out     out  12  bus: register value or BG_COLOR
// BEHAVIOUR
//  - All outputs are registered. Bus outputs update every cycle; there is no valid/stall.
//  - Bubble word: program=1, x=12'hFFF, y=12'hFFF, data=0. Register ID 0xFFF is ignored
//    by every stage. The bubble is driven in IDLE and at reset.
//  - Reset (asynchronous, any state):
//      state=IDLE, FIFO emptied, bus=bubble, busy=0, frame_done=0.
//      cfg_ready=0 while rst_n is low; it rises the first cycle after release.
//  - cfg_ready = !fifo_full in every state.
//      A push while full is impossible.
//      Push and pop in the same cycle are both honoured; the count is unchanged.
//  - FSM:
//      IDLE:    frame_go=1 -> PROGRAM if fifo count!=0, else SCAN. frame_go outside
//               IDLE is ignored.
//      PROGRAM: pop one word per cycle.
//               Emit program=1, x=target, y={9'b0,reg_id}, data=value.
//               Go to SCAN on the cycle the last word is emitted, decided on pre-push count==1.
//               A word pushed in that same cycle waits for the next frame.
//      SCAN:    program=0, data=BG_COLOR. x increments each cycle; at H_ACTIVE-1 x wraps to
//               0 and y increments. At (H-1,V-1): frame_done=1, then IDLE.
//  - Latency: frame_go high at edge N -> first program word or pixel (0,0) visible after
//    edge N+1.
//    A frame occupies count+H*V bus cycles.
//    At least one IDLE bubble separates consecutive frames, even if frame_go is held high.
//  - FIFO order is preserved, including multiple writes to the same target/register;
//    the last write wins downstream.
//  - Counter widths: ceil(log2(H_ACTIVE)) and ceil(log2(V_ACTIVE)), zero-extended to 12 bits.
// STRUCTURE
//  - render_bus_pkg holds: bus width (12), register ID constants, BUBBLE_X/BUBBLE_Y,
//    and the FSM state enum.
//  - One sub-module, cfg_fifo: synchronous FWFT FIFO, 27-bit entries, with count, full and
//    empty outputs.
//  - The top level holds the FSM, the raster counters and the output registers.
// TESTING
//  - All tests use H_ACTIVE=4, V_ACTIVE=2.
//  1. Reset with no config, then a 1-cycle frame_go:
//     -> bus shows the bubble, then pixels (0,0)..(3,0),(0,1)..(3,1) with data=000;
//        frame_done on (3,1); then the bubble.
//  2. Push (t0,r0,0x064),(t0,r1,0x032),(t0,r4,0xF00), then frame_go:
//     -> three program words in order, then 8 pixels; busy high for 11 cycles.
//  3. Push 9 words with the FIFO not popping:
//     -> cfg_ready low after the 8th accept; the 9th is held until a pop, then accepted.
//  4. Push (t1,r2,0x010) during SCAN:
//     -> it does not appear until the next frame; it is emitted first there with x=1, y=2.
//  5. Push in the same cycle as the last PROGRAM pop:
//     -> the current frame enters SCAN; the new word is emitted first next frame.
//  6. Drive rst_n low mid-SCAN at pixel (2,0):
//     -> bus is the bubble immediately, FIFO empty, no frame_done;
//        a fresh frame_go restarts at (0,0).

Source files
------------

// File: rtl/render_bus_pkg.sv
// Shared definitions for the render bus: bus width, register IDs, the bubble
// word and the scheduler state encoding.
package render_bus_pkg;

    localparam int BUS_W    = 12;
    localparam int REG_ID_W = 3;
    localparam int CFG_W    = 2 * BUS_W + REG_ID_W;   // target + reg_id + data

    localparam logic [REG_ID_W-1:0] REG_X      = 3'd0;
    localparam logic [REG_ID_W-1:0] REG_Y      = 3'd1;
    localparam logic [REG_ID_W-1:0] REG_WIDTH  = 3'd2;
    localparam logic [REG_ID_W-1:0] REG_HEIGHT = 3'd3;
    localparam logic [REG_ID_W-1:0] REG_COLOUR = 3'd4;

    // Register ID 0xFFF is ignored by every stage, so this word is a no-op.
    localparam logic [BUS_W-1:0] BUBBLE_X = 12'hFFF;
    localparam logic [BUS_W-1:0] BUBBLE_Y = 12'hFFF;

    typedef struct packed {
        logic [BUS_W-1:0]    target;
        logic [REG_ID_W-1:0] reg_id;
        logic [BUS_W-1:0]    data;
    } cfg_word_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PROGRAM = 2'd1,
        ST_SCAN    = 2'd2
    } sched_state_t;

endpackage

// File: rtl/render_stream_scheduler_cfg_fifo.sv
// cfg_fifo: synchronous first-word-fall-through FIFO for host config words.
// Ports:
//   clk, rst_n          clock, async active-low reset (empties the FIFO)
//   push_i / wdata_i    write strobe and word; ignored when full
//   pop_i               advance the read side; ignored when empty
//   rdata_o             head of FIFO, valid whenever empty_o is low
//   count_o             number of stored words, 0..DEPTH
//   full_o / empty_o    occupancy flags
module cfg_fifo
    import render_bus_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = CFG_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i  && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
        else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/render_stream_scheduler.sv
// render_stream_scheduler: buffers host config writes and sequences each frame
// on the shared program/x/y/data bus (program burst, then background raster).
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_IDLE    | bubble on the bus; waits for frame_go
//   ST_PROGRAM | emits one queued config word per cycle until the FIFO drains
//   ST_SCAN    | emits background pixels (0,0)..(H-1,V-1), then returns to IDLE
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   cfg_valid/cfg_ready                host config handshake
//   cfg_target/cfg_reg_id/cfg_data     config word fields
//   frame_go                           frame start request (IDLE only)
//   busy, frame_done                   status; frame_done marks last pixel
//   program_out/x_out/y_out/data_out   registered render bus
module render_stream_scheduler
    import render_bus_pkg::*;
#(
    parameter int               H_ACTIVE   = 640,
    parameter int               V_ACTIVE   = 480,
    parameter logic [BUS_W-1:0] BG_COLOR   = 12'h000,
    parameter int               FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [BUS_W-1:0]    cfg_target,
    input  logic [REG_ID_W-1:0] cfg_reg_id,
    input  logic [BUS_W-1:0]    cfg_data,
    input  logic                frame_go,
    output logic                busy,
    output logic                frame_done,
    output logic                program_out,
    output logic [BUS_W-1:0]    x_out,
    output logic [BUS_W-1:0]    y_out,
    output logic [BUS_W-1:0]    data_out
);

    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    sched_state_t     state_q, state_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             prog_q, prog_d;
    logic [BUS_W-1:0] bus_x_q, bus_x_d;
    logic [BUS_W-1:0] bus_y_q, bus_y_d;
    logic [BUS_W-1:0] bus_data_q, bus_data_d;

    logic             push, pop;
    cfg_word_t        fifo_head;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full, fifo_empty;

    assign push = cfg_valid && cfg_ready_q;
    assign pop  = (state_q == ST_PROGRAM) && !fifo_empty;

    cfg_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CFG_W)
    ) u_cfg_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i ({cfg_target, cfg_reg_id, cfg_data}),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // cfg_ready is registered, so it tracks the FIFO's next-cycle fullness.
    assign cfg_ready_d = !((fifo_full && !pop) ||
                           (fifo_count == CW'(FIFO_DEPTH - 1) && push && !pop));

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        prog_d     = 1'b1;
        bus_x_d    = BUBBLE_X;
        bus_y_d    = BUBBLE_Y;
        bus_data_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (frame_go) state_d = fifo_empty ? ST_SCAN : ST_PROGRAM;
            end
            ST_PROGRAM: begin
                busy_d     = 1'b1;
                bus_x_d    = fifo_head.target;
                bus_y_d    = BUS_W'(fifo_head.reg_id);
                bus_data_d = fifo_head.data;
                // Decided on the pre-push count: a word arriving now waits a frame.
                if (fifo_count == CW'(1)) state_d = ST_SCAN;
            end
            ST_SCAN: begin
                busy_d     = 1'b1;
                prog_d     = 1'b0;
                bus_x_d    = BUS_W'(x_q);
                bus_y_d    = BUS_W'(y_q);
                bus_data_d = BG_COLOR;
                if (x_q == X_LAST) begin
                    x_d = '0;
                    if (y_q == Y_LAST) begin
                        y_d     = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        y_d = y_q + YW'(1);
                    end
                end else begin
                    x_d = x_q + XW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            cfg_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            prog_q      <= 1'b1;
            bus_x_q     <= BUBBLE_X;
            bus_y_q     <= BUBBLE_Y;
            bus_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cfg_ready_q <= cfg_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            prog_q      <= prog_d;
            bus_x_q     <= bus_x_d;
            bus_y_q     <= bus_y_d;
            bus_data_q  <= bus_data_d;
        end
    end

    assign cfg_ready   = cfg_ready_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign program_out = prog_q;
    assign x_out       = bus_x_q;
    assign y_out       = bus_y_q;
    assign data_out    = bus_data_q;

endmodule

// File: tb/tb_render_stream_scheduler.sv
// Bench for render_stream_scheduler with a 4x2 raster.
module tb_render_stream_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [11:0] cfg_target;
    logic [2:0]  cfg_reg_id;
    logic [11:0] cfg_data;
    logic        frame_go;
    logic        busy;
    logic        frame_done;
    logic        program_out;
    logic [11:0] x_out;
    logic [11:0] y_out;
    logic [11:0] data_out;

    int checks = 0;
    int errors = 0;

    render_stream_scheduler #(
        .H_ACTIVE   (4),
        .V_ACTIVE   (2),
        .BG_COLOR   (12'h000),
        .FIFO_DEPTH (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_target  (cfg_target),
        .cfg_reg_id  (cfg_reg_id),
        .cfg_data    (cfg_data),
        .frame_go    (frame_go),
        .busy        (busy),
        .frame_done  (frame_done),
        .program_out (program_out),
        .x_out       (x_out),
        .y_out       (y_out),
        .data_out    (data_out)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    typedef struct {
        logic        go;
        logic        vld;
        logic [11:0] tgt;
        logic [2:0]  rid;
        logic [11:0] dat;
        logic        e_rdy;
        logic        e_busy;
        logic        e_done;
        logic        e_prog;
        logic [11:0] e_x;
        logic [11:0] e_y;
        logic [11:0] e_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic go, logic vld, logic [11:0] tgt, logic [2:0] rid,
                                logic [11:0] dat, logic e_busy, logic e_done, logic e_prog,
                                logic [11:0] e_x, logic [11:0] e_y, logic [11:0] e_data);
        vec_t v;
        v.go = go; v.vld = vld; v.tgt = tgt; v.rid = rid; v.dat = dat;
        v.e_rdy = 1'b1; v.e_busy = e_busy; v.e_done = e_done; v.e_prog = e_prog;
        v.e_x = e_x; v.e_y = e_y; v.e_data = e_data;
        return v;
    endfunction

    function automatic vec_t bub(logic go);
        return mk(go, 1'b0, 12'h0, 3'd0, 12'h0, 1'b0, 1'b0, 1'b1, 12'hFFF, 12'hFFF, 12'h000);
    endfunction

    function automatic vec_t pushv(logic [11:0] t, logic [2:0] r, logic [11:0] d);
        return mk(1'b0, 1'b1, t, r, d, 1'b0, 1'b0, 1'b1, 12'hFFF, 12'hFFF, 12'h000);
    endfunction

    function automatic vec_t progv(logic [11:0] t, logic [2:0] r, logic [11:0] d);
        return mk(1'b0, 1'b0, 12'h0, 3'd0, 12'h0, 1'b1, 1'b0, 1'b1, t, {9'b0, r}, d);
    endfunction

    task automatic add_frame(logic go);
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(go, 1'b0, 12'h0, 3'd0, 12'h0, 1'b1, (k == 7), 1'b0,
                              12'(k % 4), 12'(k / 4), 12'h000));
    endtask

    task automatic chk(string name, logic [11:0] act, logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_bus(string name, logic p, logic [11:0] x, logic [11:0] y, logic [11:0] d);
        chk({name, ".prog"}, {11'b0, program_out}, {11'b0, p});
        chk({name, ".x"}, x_out, x);
        chk({name, ".y"}, y_out, y);
        chk({name, ".data"}, data_out, d);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs until the frame_done pixel is on the bus; every pixel seen on the way is a scan pixel.
    task automatic run_to_done(string name);
        int n = 0;
        while (frame_done !== 1'b1 && n < 20) begin
            step();
            n++;
            chk({name, ".scan_prog"}, {11'b0, program_out}, 12'h000);
        end
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL %s.done_timeout: frame_done %b after %0d cycles, expected 1", name, frame_done, n);
        end
    endtask

    logic [11:0] w_t [9];
    logic [2:0]  w_r [9];
    logic [11:0] w_d [9];

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_target = '0; cfg_reg_id = '0; cfg_data = '0; frame_go = 1'b0;

        // Table: test 1 (empty frame), test 2 (three program words), frame_go held high.
        vecs.push_back(bub(1'b0));
        vecs.push_back(bub(1'b1));
        add_frame(1'b0);
        vecs.push_back(bub(1'b0));
        vecs.push_back(pushv(12'd0, 3'd0, 12'h064));
        vecs.push_back(pushv(12'd0, 3'd1, 12'h032));
        vecs.push_back(pushv(12'd0, 3'd4, 12'hF00));
        vecs.push_back(bub(1'b1));
        vecs.push_back(progv(12'd0, 3'd0, 12'h064));
        vecs.push_back(progv(12'd0, 3'd1, 12'h032));
        vecs.push_back(progv(12'd0, 3'd4, 12'hF00));
        add_frame(1'b0);
        vecs.push_back(bub(1'b1));
        add_frame(1'b1);
        vecs.push_back(bub(1'b1));
        add_frame(1'b0);
        vecs.push_back(bub(1'b0));

        #12;
        chk_bus("reset", 1'b1, 12'hFFF, 12'hFFF, 12'h000);
        chk("reset.ready", {11'b0, cfg_ready}, 12'h000);
        chk("reset.busy", {11'b0, busy}, 12'h000);
        chk("reset.done", {11'b0, frame_done}, 12'h000);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            frame_go   = vecs[i].go;
            cfg_valid  = vecs[i].vld;
            cfg_target = vecs[i].tgt;
            cfg_reg_id = vecs[i].rid;
            cfg_data   = vecs[i].dat;
            step();
            chk($sformatf("v%0d.ready", i), {11'b0, cfg_ready},   {11'b0, vecs[i].e_rdy});
            chk($sformatf("v%0d.busy", i),  {11'b0, busy},        {11'b0, vecs[i].e_busy});
            chk($sformatf("v%0d.done", i),  {11'b0, frame_done},  {11'b0, vecs[i].e_done});
            chk_bus($sformatf("v%0d", i), vecs[i].e_prog, vecs[i].e_x, vecs[i].e_y, vecs[i].e_data);
        end
        frame_go = 1'b0; cfg_valid = 1'b0;

        // Test 3: fill the FIFO, 9th word held until a pop frees a slot.
        for (int i = 0; i < 9; i++) begin
            w_t[i] = 12'(16 + i);
            w_r[i] = 3'(i % 5);
            w_d[i] = 12'(12'h100 + i);
        end
        for (int i = 0; i < 8; i++) begin
            cfg_valid = 1'b1; cfg_target = w_t[i]; cfg_reg_id = w_r[i]; cfg_data = w_d[i];
            chk($sformatf("t3.ready_pre%0d", i), {11'b0, cfg_ready}, 12'h001);
            step();
        end
        cfg_target = w_t[8]; cfg_reg_id = w_r[8]; cfg_data = w_d[8];
        chk("t3.full_after8", {11'b0, cfg_ready}, 12'h000);
        step();
        step();
        chk("t3.held", {11'b0, cfg_ready}, 12'h000);
        frame_go = 1'b1;
        step();
        frame_go = 1'b0;
        chk_bus("t3.go_bubble", 1'b1, 12'hFFF, 12'hFFF, 12'h000);
        chk("t3.still_full", {11'b0, cfg_ready}, 12'h000);
        step();
        chk_bus("t3.w0", 1'b1, w_t[0], {9'b0, w_r[0]}, w_d[0]);
        chk("t3.ready_after_pop", {11'b0, cfg_ready}, 12'h001);
        step();
        cfg_valid = 1'b0;
        for (int i = 1; i < 9; i++) begin
            chk_bus($sformatf("t3.w%0d", i), 1'b1, w_t[i], {9'b0, w_r[i]}, w_d[i]);
            step();
        end
        chk_bus("t3.first_px", 1'b0, 12'd0, 12'd0, 12'h000);
        run_to_done("t3");
        step();
        chk_bus("t3.end_bubble", 1'b1, 12'hFFF, 12'hFFF, 12'h000);

        // Test 4: a write during SCAN is deferred to the next frame.
        frame_go = 1'b1;
        step();
        frame_go = 1'b0;
        step();
        chk_bus("t4.px00", 1'b0, 12'd0, 12'd0, 12'h000);
        cfg_valid = 1'b1; cfg_target = 12'd1; cfg_reg_id = 3'd2; cfg_data = 12'h010;
        step();
        cfg_valid = 1'b0;
        chk_bus("t4.px10", 1'b0, 12'd1, 12'd0, 12'h000);
        run_to_done("t4");
        step();
        chk_bus("t4.bubble", 1'b1, 12'hFFF, 12'hFFF, 12'h000);
        frame_go = 1'b1;
        step();
        frame_go = 1'b0;
        step();
        chk_bus("t4.deferred_word", 1'b1, 12'd1, 12'd2, 12'h010);
        step();
        chk_bus("t4.next_px00", 1'b0, 12'd0, 12'd0, 12'h000);
        run_to_done("t4b");
        step();

        // Test 5: push coincident with the last PROGRAM pop.
        cfg_valid = 1'b1; cfg_target = 12'd3; cfg_reg_id = 3'd1; cfg_data = 12'h0AA;
        step();
        cfg_valid = 1'b0;
        frame_go = 1'b1;
        step();
        frame_go = 1'b0;
        cfg_valid = 1'b1; cfg_target = 12'd5; cfg_reg_id = 3'd3; cfg_data = 12'h055;
        step();
        cfg_valid = 1'b0;
        chk_bus("t5.w1", 1'b1, 12'd3, 12'd1, 12'h0AA);
        step();
        chk_bus("t5.scan_now", 1'b0, 12'd0, 12'd0, 12'h000);
        run_to_done("t5");
        step();
        frame_go = 1'b1;
        step();
        frame_go = 1'b0;
        step();
        chk_bus("t5.w2_next_frame", 1'b1, 12'd5, 12'd3, 12'h055);
        step();
        chk_bus("t5.next_px00", 1'b0, 12'd0, 12'd0, 12'h000);
        run_to_done("t5b");
        step();

        // Test 6: reset mid-SCAN at pixel (2,0) with a word queued.
        frame_go = 1'b1;
        step();
        frame_go = 1'b0;
        step();
        cfg_valid = 1'b1; cfg_target = 12'd7; cfg_reg_id = 3'd0; cfg_data = 12'h123;
        step();
        cfg_valid = 1'b0;
        step();
        chk_bus("t6.px20", 1'b0, 12'd2, 12'd0, 12'h000);
        #2;
        rst_n = 1'b0;
        #1;
        chk_bus("t6.reset_bubble", 1'b1, 12'hFFF, 12'hFFF, 12'h000);
        chk("t6.reset_busy", {11'b0, busy}, 12'h000);
        chk("t6.reset_done", {11'b0, frame_done}, 12'h000);
        chk("t6.reset_ready", {11'b0, cfg_ready}, 12'h000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("t6.ready_after", {11'b0, cfg_ready}, 12'h001);
        chk("t6.no_done", {11'b0, frame_done}, 12'h000);
        frame_go = 1'b1;
        step();
        frame_go = 1'b0;
        chk_bus("t6.go_bubble", 1'b1, 12'hFFF, 12'hFFF, 12'h000);
        step();
        chk_bus("t6.restart_px00", 1'b0, 12'd0, 12'd0, 12'h000);
        run_to_done("t6");
        step();
        chk_bus("t6.end_bubble", 1'b1, 12'hFFF, 12'hFFF, 12'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
